exec_mem_unit: RTL and testbench
================================

# exec_mem_unit

Execute/memory slice of the single-cycle MIPS datapath: 16-bit immediate extender, 32-bit ALU with equality flag, and a 1024-word data memory with word store, word load and signed byte load. Sits between the register file (operand source) and the write-back mux; the instruction-fetch unit consumes `ext_out` and `com_result` for branches.

## Interface
Parameters:
- DM_WORDS, 1024, data memory depth in 32-bit words; address index is `alu_c[11:2]`.

Ports:
- clk  in  1  system clock; memory writes and clears occur on its rising edge.
- reset  in  1  synchronous, active-high; clears every memory word to 0 on the next rising edge.
- pc  in  32  address of the current instruction; used only for the write log.
- imm16  in  16  immediate field, `instr[15:0]`.
- ext_op  in  1  1 = sign-extend, 0 = zero-extend.
- shamt  in  5  shift amount, `instr[10:6]`.
- rs_data  in  32  ALU operand A.
- rt_data  in  32  second register operand; ALU B when `alu_src`=0, store data always.
- alu_src  in  1  0 = B is `rt_data`, 1 = B is `ext_out`.
- alu_op  in  3  operation select (see Operation).
- mem_write  in  1  store word enable.
- lb  in  1  1 = byte-load mode on `dm_dout`.
- ext_out  out  32  extended immediate.
- alu_c  out  32  ALU result; also the memory byte address.
- com_result  out  1  1 when A == B (full 32-bit compare).
- dm_dout  out  32  load data.

## Operation
- Extender: `ext_out = ext_op ? {{16{imm16[15]}}, imm16} : {16'b0, imm16}`.
- B = `alu_src ? ext_out : rt_data`.
- ALU (all 32-bit, wrap-around, no overflow trap/flag):
  - 000 addu A+B; 001 subu A−B; 010 or A|B; 011 and A&B;
  - 100 lui B<<16; 101 sll B<<shamt; 110 slt signed (A<B)?1:0; 111 xor A^B.
- `com_result` is independent of `alu_op`.
- Memory index `idx = alu_c[11:2]`; `alu_c[31:12]` ignored; `alu_c[1:0]` ignored for words.
- Store: when `mem_write`=1 and `reset`=0, `mem[idx] <= rt_data` at posedge.
- Load, combinational: `lb`=0 → `mem[idx]`; `lb`=1 → byte `alu_c[1:0]` of `mem[idx]` (little-endian: 0 = bits 7:0 … 3 = bits 31:24), sign-extended to 32 bits.
- `reset` takes priority over `mem_write` in the same cycle: memory clears, store discarded.

## Timing
- Extender, ALU, `com_result`, `dm_dout` purely combinational; zero-cycle latency.
- Store visible on `dm_dout` immediately after the writing edge (read-after-write same address next cycle returns new data).
- Read during the write cycle returns the old word.
- Memory contents are 0 after simulation start (initial clear) and after any reset edge; hence `dm_dout` = 0 after reset for all addresses.
- Reset mid-operation: everything stored earlier is lost at that edge.

## Configuration
- `DM_WRITE_LOG_EN`: when defined, every accepted store prints `@<pc hex>: *<byte address hex> <= <data hex>` with byte address `{20'b0, idx, 2'b00}` at the writing edge. When undefined, no display statements are compiled; functional behaviour identical.

## Test plan
- Extend: imm16=16'h8000, ext_op=1 → ext_out=32'hFFFF8000; ext_op=0 → 32'h00008000.
- ALU: A=32'hFFFFFFFF, B=1, op 000 → 0; op 001 → 32'hFFFFFFFE; op 110 → 1; A=B=5 → com_result=1; op 100, B=32'h1234 → 32'h12340000; op 101, shamt=4, B=1 → 16.
- Store/load: alu_c=32'h0000_0010, rt_data=32'h80FF7F01, mem_write=1 one edge → lb=0 dm_dout=32'h80FF7F01; lb=1 with addr 0x10/0x11/0x12/0x13 → 1, 0x7F, 32'hFFFFFFFF, 32'hFFFFFF80.
- Address aliasing: store at 32'h0000_1010 then read 32'h0000_0010 → same word.
- Reset priority: reset=1 and mem_write=1 same edge → all words 0, dm_dout=0.
- With DM_WRITE_LOG_EN, pc=32'h3004, store 32'h12 to 0x8 → one line `@00003004: *00000008 <= 00000012`.

Source files
------------

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: immediate extender, 32-bit ALU with equality flag, word-addressed data memory.
// Define DM_WRITE_LOG_EN to print one line for each accepted store.
module exec_mem_unit #(
    parameter int DM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    input  logic [15:0] i_imm16,
    input  logic        i_ext_op,
    input  logic [4:0]  i_shamt,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic        i_alu_src,
    input  logic [2:0]  i_alu_op,
    input  logic        i_mem_write,
    input  logic        i_lb,
    output logic [31:0] o_ext_out,
    output logic [31:0] o_alu_c,
    output logic        o_com_result,
    output logic [31:0] o_dm_dout
);
    localparam int AW = $clog2(DM_WORDS);

    logic [31:0] w_ext;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;

    logic [31:0] r_mem [DM_WORDS] = '{default: '0};

    assign w_ext = i_ext_op ? {{16{i_imm16[15]}}, i_imm16} : {16'b0, i_imm16};
    assign w_b   = i_alu_src ? w_ext : i_rt_data;

    always_comb begin
        w_alu = '0;
        case (i_alu_op)
            3'b000: w_alu = i_rs_data + w_b;
            3'b001: w_alu = i_rs_data - w_b;
            3'b010: w_alu = i_rs_data | w_b;
            3'b011: w_alu = i_rs_data & w_b;
            3'b100: w_alu = {w_b[15:0], 16'b0};
            3'b101: w_alu = w_b << i_shamt;
            3'b110: w_alu = {31'b0, $signed(i_rs_data) < $signed(w_b)};
            3'b111: w_alu = i_rs_data ^ w_b;
            default: w_alu = '0;
        endcase
    end

    // Upper address bits beyond the memory depth alias onto the same words.
    assign w_idx  = w_alu[AW+1:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_alu[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign o_ext_out    = w_ext;
    assign o_alu_c      = w_alu;
    assign o_com_result = (i_rs_data == w_b);
    assign o_dm_dout    = i_lb ? {{24{w_byte[7]}}, w_byte} : w_word;

    // Reset wipes the whole array and wins over a same-cycle store.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
        end else if (i_mem_write) begin
            r_mem[w_idx] <= i_rt_data;
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_mem_write)
            $display("@%h: *%h <= %h", i_pc, {{(30-AW){1'b0}}, w_idx, 2'b00}, i_rt_data);
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^i_pc;
`endif

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit: extender, ALU, flag, store/load, aliasing, reset.
module tb_exec_mem_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [15:0] imm16;
    logic        ext_op;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_write;
    logic        lb;
    logic [31:0] ext_out;
    logic [31:0] alu_c;
    logic        com_result;
    logic [31:0] dm_dout;

    int n_vec = 0;
    int n_err = 0;

    exec_mem_unit dut (
        .i_clk(clk), .i_reset(reset), .i_pc(pc), .i_imm16(imm16), .i_ext_op(ext_op),
        .i_shamt(shamt), .i_rs_data(rs_data), .i_rt_data(rt_data), .i_alu_src(alu_src),
        .i_alu_op(alu_op), .i_mem_write(mem_write), .i_lb(lb),
        .o_ext_out(ext_out), .o_alu_c(alu_c), .o_com_result(com_result), .o_dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a byte address on alu_c: rs + zero-extended 0 via addu.
    task automatic set_addr(input logic [31:0] a);
        rs_data = a; imm16 = 16'h0; ext_op = 1'b0; alu_src = 1'b1; alu_op = 3'b000;
    endtask

    initial begin
        reset = 1'b1; pc = 32'h0; imm16 = '0; ext_op = 1'b0; shamt = '0;
        rs_data = '0; rt_data = '0; alu_src = 1'b0; alu_op = 3'b000; mem_write = 1'b0; lb = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        set_addr(32'h10); #1; chk("rst_dout_10", dm_dout, 32'h0);
        set_addr(32'hFFC); #1; chk("rst_dout_ffc", dm_dout, 32'h0);

        imm16 = 16'h8000; ext_op = 1'b1; #1; chk("ext_sign", ext_out, 32'hFFFF8000);
        ext_op = 1'b0; #1; chk("ext_zero", ext_out, 32'h00008000);

        alu_src = 1'b0; rs_data = 32'hFFFFFFFF; rt_data = 32'h1;
        alu_op = 3'b000; #1; chk("addu_wrap", alu_c, 32'h0);
        chk("com_ne", {31'b0, com_result}, 32'h0);
        alu_op = 3'b001; #1; chk("subu", alu_c, 32'hFFFFFFFE);
        alu_op = 3'b110; #1; chk("slt_neg", alu_c, 32'h1);
        rs_data = 32'h1; rt_data = 32'hFFFFFFFF; #1; chk("slt_pos", alu_c, 32'h0);
        rs_data = 32'h5; rt_data = 32'h5; #1; chk("com_eq", {31'b0, com_result}, 32'h1);
        alu_op = 3'b100; rt_data = 32'h1234; #1; chk("lui", alu_c, 32'h12340000);
        alu_op = 3'b101; shamt = 5'd4; rt_data = 32'h1; #1; chk("sll", alu_c, 32'h10);
        rs_data = 32'h0F0F0F0F; rt_data = 32'h00FF00FF;
        alu_op = 3'b010; #1; chk("or", alu_c, 32'h0FFF0FFF);
        alu_op = 3'b011; #1; chk("and", alu_c, 32'h000F000F);
        alu_op = 3'b111; #1; chk("xor", alu_c, 32'h0FF00FF0);
        rs_data = 32'h10; imm16 = 16'hFFFF; ext_op = 1'b1; alu_src = 1'b1; alu_op = 3'b000;
        #1; chk("addu_imm", alu_c, 32'hF);
        rs_data = 32'hFFFFFFFF; #1; chk("com_imm", {31'b0, com_result}, 32'h1);

        // Store; read during the write cycle still returns the old word.
        set_addr(32'h10); rt_data = 32'h80FF7F01; mem_write = 1'b1; pc = 32'h3004;
        #1; chk("rd_during_wr", dm_dout, 32'h0);
        @(posedge clk); #1;
        mem_write = 1'b0; #1;
        chk("lw_10", dm_dout, 32'h80FF7F01);
        lb = 1'b1;
        set_addr(32'h10); #1; chk("lb_10", dm_dout, 32'h00000001);
        set_addr(32'h11); #1; chk("lb_11", dm_dout, 32'h0000007F);
        set_addr(32'h12); #1; chk("lb_12", dm_dout, 32'hFFFFFFFF);
        set_addr(32'h13); #1; chk("lb_13", dm_dout, 32'hFFFFFF80);
        lb = 1'b0;
        set_addr(32'h11); #1; chk("lw_unaligned", dm_dout, 32'h80FF7F01);

        // Aliasing: bit 12 and above are ignored.
        set_addr(32'h1010); rt_data = 32'hCAFEF00D; mem_write = 1'b1;
        @(posedge clk); #1;
        mem_write = 1'b0;
        set_addr(32'h10); #1; chk("alias", dm_dout, 32'hCAFEF00D);
        set_addr(32'h14); rt_data = 32'h11111111; mem_write = 1'b1;
        @(posedge clk); #1;
        mem_write = 1'b0; #1; chk("lw_14", dm_dout, 32'h11111111);

        // Reset beats a same-cycle store and wipes earlier stores.
        set_addr(32'h18); rt_data = 32'h22222222; mem_write = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_write = 1'b0;
        #1; chk("rst_prio_18", dm_dout, 32'h0);
        set_addr(32'h10); #1; chk("rst_clr_10", dm_dout, 32'h0);
        set_addr(32'h14); #1; chk("rst_clr_14", dm_dout, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
